// File: rtl/jtvigil_sndrom_arb.sv
// Sound ROM arbiter: CPU program fetch and PCM sample fetch share one
// ROM slot, each side has a one-entry hit cache, ties alternate.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cpu_cs/addr/data/ok     CPU fetch side; ok = cs && cache hit
//   pcm_cs/addr/data/ok     PCM fetch side; ok = cs && cache hit
//   rom_cs/addr/data/ok     downstream ROM/SDRAM slot
module jtvigil_sndrom_arb #(
  parameter int AW     = 17,
  parameter int CPU_AW = 15,
  parameter int PCM_AW = 16,
  parameter logic [AW-1:0] PCM_BASE = 17'h08000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cs,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_ok,
  input  logic              pcm_cs,
  input  logic [PCM_AW-1:0] pcm_addr,
  output logic [7:0]        pcm_data,
  output logic              pcm_ok,
  output logic              rom_cs,
  output logic [AW-1:0]     rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok
);

  localparam int RW = (CPU_AW > PCM_AW) ? CPU_AW : PCM_AW;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic              gnt_pcm_q, gnt_pcm_d;
  logic              last_pcm_q, last_pcm_d;
  logic              rom_cs_q, rom_cs_d;
  logic [AW-1:0]     rom_addr_q, rom_addr_d;
  logic [RW-1:0]     req_q, req_d;
  logic [CPU_AW-1:0] cpu_tag_q, cpu_tag_d;
  logic [7:0]        cpu_dat_q, cpu_dat_d;
  logic              cpu_vld_q, cpu_vld_d;
  logic [PCM_AW-1:0] pcm_tag_q, pcm_tag_d;
  logic [7:0]        pcm_dat_q, pcm_dat_d;
  logic              pcm_vld_q, pcm_vld_d;

  logic          cpu_hit, pcm_hit;
  logic          cpu_pend, pcm_pend;
  logic          pick_pcm;
  logic [AW-1:0] cpu_rom, pcm_rom;

  assign cpu_hit  = cpu_vld_q && (cpu_tag_q == cpu_addr);
  assign pcm_hit  = pcm_vld_q && (pcm_tag_q == pcm_addr);
  assign cpu_pend = cpu_cs && !cpu_hit;
  assign pcm_pend = pcm_cs && !pcm_hit;
  // Tie goes to whoever was not granted last time.
  assign pick_pcm = pcm_pend && (!cpu_pend || !last_pcm_q);

  assign cpu_rom = AW'(cpu_addr);
  assign pcm_rom = PCM_BASE + AW'(pcm_addr);

  assign cpu_ok   = cpu_cs && cpu_hit;
  assign pcm_ok   = pcm_cs && pcm_hit;
  assign cpu_data = cpu_dat_q;
  assign pcm_data = pcm_dat_q;
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    gnt_pcm_d  = gnt_pcm_q;
    last_pcm_d = last_pcm_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    req_d      = req_q;
    cpu_tag_d  = cpu_tag_q;
    cpu_dat_d  = cpu_dat_q;
    cpu_vld_d  = cpu_vld_q;
    pcm_tag_d  = pcm_tag_q;
    pcm_dat_d  = pcm_dat_q;
    pcm_vld_d  = pcm_vld_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_pend || pcm_pend) begin
          gnt_pcm_d  = pick_pcm;
          last_pcm_d = pick_pcm;
          rom_cs_d   = 1'b1;
          first_d    = 1'b1;
          rom_addr_d = pick_pcm ? pcm_rom : cpu_rom;
          req_d      = pick_pcm ? RW'(pcm_addr) : RW'(cpu_addr);
          state_d    = SERVE;
        end
      end
      SERVE: begin
        // First cycle: rom_ok may still be the previous access's.
        if (first_q) begin
          first_d = 1'b0;
        end else if (rom_ok) begin
          rom_cs_d = 1'b0;
          state_d  = GAP;
          if (gnt_pcm_q) begin
            pcm_tag_d = PCM_AW'(req_q);
            pcm_dat_d = rom_data;
            pcm_vld_d = 1'b1;
          end else begin
            cpu_tag_d = CPU_AW'(req_q);
            cpu_dat_d = rom_data;
            cpu_vld_d = 1'b1;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      gnt_pcm_q  <= 1'b0;
      last_pcm_q <= 1'b1;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      req_q      <= '0;
      cpu_tag_q  <= '0;
      cpu_dat_q  <= '0;
      cpu_vld_q  <= 1'b0;
      pcm_tag_q  <= '0;
      pcm_dat_q  <= '0;
      pcm_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      gnt_pcm_q  <= gnt_pcm_d;
      last_pcm_q <= last_pcm_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      req_q      <= req_d;
      cpu_tag_q  <= cpu_tag_d;
      cpu_dat_q  <= cpu_dat_d;
      cpu_vld_q  <= cpu_vld_d;
      pcm_tag_q  <= pcm_tag_d;
      pcm_dat_q  <= pcm_dat_d;
      pcm_vld_q  <= pcm_vld_d;
    end
  end

endmodule

// File: doc/jtvigil_sndrom_arb.md
Name: jtvigil_sndrom_arb

Overview:
- Shares one downstream ROM/SDRAM slot between two requesters in the sound subsystem: the Z80 program fetch and the PCM sample fetch.
- Each requester has a one-entry hit cache, so a repeated address returns data without a new ROM access.
- Misses are serialised through a small FSM. Both requesters being pending at once is resolved by alternating priority.
- Sits between the sound CPU/PCM address counter and the framework SDRAM port.

Parameters:
- AW, 17, downstream ROM address width.
- CPU_AW, 15, CPU program address width (32 kB program region).
- PCM_AW, 16, PCM sample address width.
- PCM_BASE, 17'h08000, ROM offset of the PCM region.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cpu_cs  in  1  CPU fetch request
- cpu_addr  in  CPU_AW  CPU fetch address
- cpu_data  out  8  CPU fetch data
- cpu_ok  out  1  cpu_data valid for the current cpu_addr
- pcm_cs  in  1  PCM fetch request
- pcm_addr  in  PCM_AW  PCM sample address
- pcm_data  out  8  PCM sample data
- pcm_ok  out  1  pcm_data valid for the current pcm_addr
- rom_cs  out  1  downstream request
- rom_addr  out  AW  downstream address
- rom_data  in  8  downstream data
- rom_ok  in  1  downstream data valid for the held rom_addr

Behaviour:
- Reset values (asynchronous, rst_n low):
  - FSM = IDLE; rom_cs = 0; rom_addr = 0.
  - cpu_data = 0, pcm_data = 0.
  - Both cache valid bits = 0; cached tags = 0; last_grant = PCM, so CPU wins the first tie.
  - cpu_ok and pcm_ok are therefore 0.
- Cache per requester: registered tag, data byte and valid bit.
  - hit = valid && (tag == addr).
  - ok = cs && hit. This is combinational from registered state and the live address, so ok drops in the same cycle the address changes.
  - data output is the cached byte.
- A requester is pending when cs && !hit.
- Address mapping:
  - CPU: rom_addr = zero-extended cpu_addr.
  - PCM: rom_addr = PCM_BASE + pcm_addr, truncated to AW bits, with no carry out.
- FSM states: IDLE, SERVE, GAP.
- IDLE:
  - No pending requester: stay; rom_cs = 0.
  - One pending requester: grant it.
  - Both pending: grant the one not equal to last_grant.
  - On grant, register rom_addr from the granted address, set rom_cs = 1 and set last_grant, all at the same clock edge; go to SERVE.
- SERVE:
  - rom_cs stays 1 and rom_addr stays constant.
  - rom_ok is ignored in the first SERVE cycle, because a stale ok from the previous access may still be high.
  - From the second cycle on, when rom_ok = 1:
    - capture rom_data into the granted cache;
    - tag = the address latched at grant;
    - valid = 1;
    - rom_cs = 0;
    - go to GAP.
  - No timeout; SERVE waits indefinitely for rom_ok.
- GAP: one cycle with rom_cs = 0 so downstream sees a fresh request edge; then return to IDLE.
- Miss latency:
  - Request seen in cycle 0; rom_cs high from cycle 1.
  - Earliest rom_ok accepted in cycle 2.
  - ok asserted the cycle after capture.
  - The next grant happens no earlier than 2 cycles after capture (GAP, then IDLE).
- Boundary rules:
  - Requester address changes during SERVE: the fetch completes and fills the cache with the old address. The new address then misses and is re-arbitrated.
  - cs drops during SERVE: the fetch completes and the cache is still filled.
  - Hits from the non-granted requester are served from its cache during SERVE; there is no stall.
  - Async reset during SERVE: rom_cs goes to 0 immediately and the in-flight result is discarded.
  - rom_ok high while in IDLE or GAP: ignored.

Test Plan:
- Reset, cpu_cs = 1, cpu_addr = 15'h1234; rom_ok rises 3 cycles after rom_cs with rom_data = 8'hA5.
  - Expect rom_addr = 17'h01234 and one rom_cs pulse.
  - Expect cpu_ok = 1 and cpu_data = 8'hA5 the cycle after capture.
  - Re-present 15'h1234: cpu_ok immediate, no new rom_cs.
- pcm_cs = 1, pcm_addr = 16'h0010, then 16'hFFFF.
  - Expect rom_addr = 17'h08010, then 17'h17FFF.
  - pcm_data follows the rom_data given for each access.
- Both requesters miss in the same cycle after reset.
  - Expect the CPU grant first, then PCM after GAP.
  - A second simultaneous miss pair is granted PCM first.
- rom_ok held high from the previous access at the first SERVE cycle.
  - Expect it ignored: no capture on that cycle; capture on the next rom_ok-high cycle.
- cpu_addr changes from 15'h0100 to 15'h0101 during SERVE.
  - Expect the tag filled with 15'h0100 and cpu_ok = 0.
  - Expect a second access with rom_addr = 17'h00101.
- rst_n pulsed low mid-SERVE.
  - Expect rom_cs = 0 asynchronously and cpu_ok = pcm_ok = 0.
  - Previously cached addresses miss after release.
